ps2_mouse_device_tx: RTL and testbench

Device-side PS/2 mouse transmitter: accepts one movement/button report, encodes it into the standard 3-byte mouse packet, and serialises it onto open-collector PS/2 clock/data lines, generating the clock itself as a mouse does. It is the counterpart of PS2_Controller plus PS2_Mouse_Parser on the host side. It serves as an on-board mouse emulator and as a bit-accurate stimulus source for host-path benches.

---
 rtl/ps2_mouse_device_tx.sv | 258 +++++++++++++++++++++++++
 tb/tb_ps2_mouse_device_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_device_tx.sv
// Purpose: device-side PS/2 mouse transmitter; latches one report, builds the
//          3-byte mouse packet and clocks it out on open-collector clk/data.
// Latency: packet done pulse 66*CLK_HALF + 2*INTER_BYTE_GAP cycles after accept.
// Backpressure: pkt_ready high only while idle; pkt_valid outside idle is dropped.
//
// Ports:
//   CLOCK_50, reset_n         system clock, async active-low reset
//   delta_x, delta_y, buttons report fields (9-bit two's complement, {M,R,L})
//   pkt_valid / pkt_ready     report handshake, transfer on valid && ready
//   ps2_clk_in                observed PS/2 clock line level (async)
//   ps2_clk_oe, ps2_dat_oe    1 = pull the line low, 0 = release
//   done                      one-cycle pulse as the last bit cell of a packet ends
//
// Build option: define PS2_TX_INHIBIT_DETECT_EN to abort and retry the packet
// when the host holds the clock line low.
module ps2_mouse_device_tx #(
  parameter int CLK_HALF       = 1250,
  parameter int INTER_BYTE_GAP = 2500
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [8:0] delta_x,
  input  logic [8:0] delta_y,
  input  logic [2:0] buttons,
  input  logic       pkt_valid,
  output logic       pkt_ready,
  input  logic       ps2_clk_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       done
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_BIT_H    = 3'd1;
  localparam logic [2:0] ST_BIT_L    = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
`ifdef PS2_TX_INHIBIT_DETECT_EN
  localparam logic [2:0] ST_WAIT_INH = 3'd4;
`endif

  // Timer reload values: the timer counts down to zero, so a state lasting N
  // cycles is loaded with N-1 on entry.
  localparam logic [15:0] HALF_LOAD = 16'(CLK_HALF - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(INTER_BYTE_GAP - 1);
`ifdef PS2_TX_INHIBIT_DETECT_EN
  localparam logic [15:0] WAIT_LOAD = 16'(2 * CLK_HALF - 1);
`endif
  localparam logic [3:0]  LAST_BIT  = 4'd10;
  localparam logic [1:0]  LAST_BYTE = 2'd2;

  typedef struct packed {
    logic [7:0] b2;
    logic [7:0] b1;
    logic [7:0] b0;
  } pkt_t;

  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  pkt_t        pkt_q, pkt_d;

  logic        accept;
  logic        timer_zero;
  logic [7:0]  cur_byte;
  logic [15:0] cur_frame;
  logic        cur_bit;

  // ---------------------------------------------------------------------------
  // Host inhibit detection
  // ---------------------------------------------------------------------------
`ifdef PS2_TX_INHIBIT_DETECT_EN
  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic oe_d1_q, oe_d1_d;
  logic oe_d2_q, oe_d2_d;
  logic line_low;

  always_comb begin
    clk_meta_d = ps2_clk_in;
    clk_sync_d = clk_meta_q;
    oe_d1_d    = ps2_clk_oe;
    oe_d2_d    = oe_d1_q;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      oe_d1_q    <= 1'b0;
      oe_d2_q    <= 1'b0;
    end else begin
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      oe_d1_q    <= oe_d1_d;
      oe_d2_q    <= oe_d2_d;
    end
  end

  // The synchronised level lags the pin by two cycles, so our own low phase
  // is still visible for two cycles after we release the clock. Compare
  // against our drive delayed by the same amount, so only a low level that
  // we are not causing is taken as the host inhibiting.
  assign line_low = ~clk_sync_q & ~oe_d2_q & ~ps2_clk_oe;
`else
  // Without inhibit detection the clock line is not observed.
  logic unused_clk_in;
  assign unused_clk_in = ps2_clk_in;
`endif

  // ---------------------------------------------------------------------------
  // Current bit selection
  // ---------------------------------------------------------------------------
  always_comb begin
    case (byte_idx_q)
      2'd0:    cur_byte = pkt_q.b0;
      2'd1:    cur_byte = pkt_q.b1;
      default: cur_byte = pkt_q.b2;
    endcase
  end

  // Frame bit order from index 0: start, data LSB..MSB, odd parity, stop.
  // Unused upper positions read as 1 (idle line level).
  assign cur_frame  = {5'b11111, 1'b1, ~^cur_byte, cur_byte, 1'b0};
  assign cur_bit    = cur_frame[bit_idx_q];

  assign timer_zero = (timer_q == 16'd0);
  assign accept     = pkt_valid && pkt_ready;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    pkt_d      = pkt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pkt_d.b0   = {2'b00, delta_y[8], delta_x[8], 1'b1, buttons};
          pkt_d.b1   = delta_x[7:0];
          pkt_d.b2   = delta_y[7:0];
          byte_idx_d = 2'd0;
          bit_idx_d  = 4'd0;
          state_d    = ST_BIT_H;
          timer_d    = HALF_LOAD;
`ifdef PS2_TX_INHIBIT_DETECT_EN
          // Host already holding the clock: keep the report and wait.
          if (line_low) begin
            state_d = ST_WAIT_INH;
            timer_d = WAIT_LOAD;
          end
`endif
        end
      end

      ST_BIT_H: begin
        if (timer_zero) begin
          state_d = ST_BIT_L;
          timer_d = HALF_LOAD;
        end else begin
          timer_d = timer_q - 16'd1;
        end
`ifdef PS2_TX_INHIBIT_DETECT_EN
        // The stop bit is already committed; an inhibit there is not an abort.
        if (line_low && (bit_idx_q < LAST_BIT)) begin
          state_d = ST_WAIT_INH;
          timer_d = WAIT_LOAD;
        end
`endif
      end

      ST_BIT_L: begin
        if (timer_zero) begin
          if (bit_idx_q < LAST_BIT) begin
            bit_idx_d = bit_idx_q + 4'd1;
            state_d   = ST_BIT_H;
            timer_d   = HALF_LOAD;
          end else if (byte_idx_q < LAST_BYTE) begin
            state_d = ST_GAP;
            timer_d = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      ST_GAP: begin
        if (timer_zero) begin
          byte_idx_d = byte_idx_q + 2'd1;
          bit_idx_d  = 4'd0;
          state_d    = ST_BIT_H;
          timer_d    = HALF_LOAD;
        end else begin
          timer_d = timer_q - 16'd1;
        end
`ifdef PS2_TX_INHIBIT_DETECT_EN
        if (line_low) begin
          state_d = ST_WAIT_INH;
          timer_d = WAIT_LOAD;
        end
`endif
      end

`ifdef PS2_TX_INHIBIT_DETECT_EN
      ST_WAIT_INH: begin
        // Timer counts consecutive high cycles; any low sample restarts it.
        if (!clk_sync_q) begin
          timer_d = WAIT_LOAD;
        end else if (timer_zero) begin
          byte_idx_d = 2'd0;
          bit_idx_d  = 4'd0;
          state_d    = ST_BIT_H;
          timer_d    = HALF_LOAD;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= 16'd0;
      byte_idx_q <= 2'd0;
      bit_idx_q  <= 4'd0;
      pkt_q      <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      pkt_q      <= pkt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded straight from state flops so reset releases the lines
  // immediately, without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  assign pkt_ready  = (state_q == ST_IDLE);
  assign ps2_clk_oe = (state_q == ST_BIT_L);
  assign ps2_dat_oe = ((state_q == ST_BIT_H) || (state_q == ST_BIT_L)) && !cur_bit;
  assign done       = (state_q == ST_BIT_L) && timer_zero &&
                      (bit_idx_q == LAST_BIT) && (byte_idx_q == LAST_BYTE);

endmodule

// File: tb/tb_ps2_mouse_device_tx.sv
// Bench for ps2_mouse_device_tx with CLK_HALF = 4, INTER_BYTE_GAP = 8.
// A host-side monitor decodes a bit on every falling edge the device drives
// on the clock line and counts done pulses; packets are compared against
// frames built from the report fields with plain arithmetic.
module tb_ps2_mouse_device_tx;

  localparam int CH  = 4;
  localparam int IBG = 8;
  localparam int LAT = 280;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic [8:0] delta_x;
  logic [8:0] delta_y;
  logic [2:0] buttons;
  logic       pkt_valid;
  logic       pkt_ready;
  logic       ps2_clk_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       done;
  logic       host_pull;

  always #5 CLOCK_50 = ~CLOCK_50;

  // Open-collector clock line as seen by the device.
  assign ps2_clk_in = ~(ps2_clk_oe | host_pull);

  ps2_mouse_device_tx #(.CLK_HALF(CH), .INTER_BYTE_GAP(IBG)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .delta_x    (delta_x),
    .delta_y    (delta_y),
    .buttons    (buttons),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .done       (done)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   fall_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic clk_oe_prev = 1'b0;
  bit   bits[$];

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Host decoder: sample data on each falling edge of the device clock.
  always @(negedge CLOCK_50) begin
    if (ps2_clk_oe && !clk_oe_prev) begin
      bits.push_back(!ps2_dat_oe);
      fall_cnt <= fall_cnt + 1;
    end
    clk_oe_prev <= ps2_clk_oe;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Reference model: expected 11-bit frame (bit 0 = start) for byte idx.
  function automatic logic [10:0] model_frame(int dx, int dy, int btn, int idx);
    int v;
    int ones;
    case (idx)
      0:       v = (dy < 0 ? 32 : 0) + (dx < 0 ? 16 : 0) + 8 + btn;
      1:       v = (dx + 256) % 256;
      default: v = (dy + 256) % 256;
    endcase
    ones = 0;
    for (int i = 0; i < 8; i++) ones += (v >> i) & 1;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, 8'(v), 1'b0};
  endfunction

  function automatic logic [10:0] mk_frame(logic [7:0] b, logic par);
    return {1'b1, par, b, 1'b0};
  endfunction

  function automatic logic [10:0] frame_at(int k);
    logic [10:0] f;
    for (int j = 0; j < 11; j++) f[j] = bits[k * 11 + j];
    return f;
  endfunction

  // Caller is just after a rising edge; the accept happens on the next one.
  task automatic send(input int dx, input int dy, input int btn, output int t);
    delta_x   = 9'(dx);
    delta_y   = 9'(dy);
    buttons   = 3'(btn);
    pkt_valid = 1'b1;
    t         = cyc;
    tick();
    pkt_valid = 1'b0;
  endtask

  task automatic start_checks(input string nm);
    chk({nm, "_start_dat_oe"}, ps2_dat_oe, 1);
    chk({nm, "_start_ready"},  pkt_ready, 0);
    chk({nm, "_start_clk_oe"}, ps2_clk_oe, 0);
  endtask

  // Waits for the done pulse (bounded) and checks latency and the frames.
  task automatic finish_pkt(input string nm, input int t, input int d0, input bit check_lat,
                            input logic [10:0] e0, input logic [10:0] e1, input logic [10:0] e2);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      tick();
      if (done_cnt != d0) ok = 1'b1;
    end
    chk({nm, "_done_seen"}, ok, 1);
    if (ok) begin
      if (check_lat) chk({nm, "_done_latency"}, done_cyc - t, LAT);
      chk({nm, "_ready_after_done"}, pkt_ready, 1);
      chk({nm, "_done_single"}, done, 0);
    end
    chk({nm, "_bit_count"}, bits.size(), 33);
    if (bits.size() == 33) begin
      chk({nm, "_byte0"}, frame_at(0), e0);
      chk({nm, "_byte1"}, frame_at(1), e1);
      chk({nm, "_byte2"}, frame_at(2), e2);
    end
  endtask

  typedef struct {
    int          dx;
    int          dy;
    int          btn;
    logic [10:0] f0;
    logic [10:0] f1;
    logic [10:0] f2;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t, t2, d0, fc;

    // Hand-derived vectors, then random ones priced by the model.
    vecs[0] = '{5,    -3, 1, mk_frame(8'h29, 1'b0), mk_frame(8'h05, 1'b1), mk_frame(8'hFD, 1'b0)};
    vecs[1] = '{-256,  0, 6, mk_frame(8'h1E, 1'b1), mk_frame(8'h00, 1'b1), mk_frame(8'h00, 1'b1)};
    vecs[2] = '{255,  -1, 7, mk_frame(8'h2F, 1'b0), mk_frame(8'hFF, 1'b1), mk_frame(8'hFF, 1'b1)};
    for (int i = 3; i < 8; i++) begin
      vecs[i].dx  = int'($urandom_range(511, 0)) - 256;
      vecs[i].dy  = int'($urandom_range(511, 0)) - 256;
      vecs[i].btn = int'($urandom_range(7, 0));
      vecs[i].f0  = model_frame(vecs[i].dx, vecs[i].dy, vecs[i].btn, 0);
      vecs[i].f1  = model_frame(vecs[i].dx, vecs[i].dy, vecs[i].btn, 1);
      vecs[i].f2  = model_frame(vecs[i].dx, vecs[i].dy, vecs[i].btn, 2);
    end

    reset_n   = 1'b0;
    pkt_valid = 1'b0;
    host_pull = 1'b0;
    delta_x   = '0;
    delta_y   = '0;
    buttons   = '0;

    // Reset values.
    repeat (3) tick();
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_dat_oe", ps2_dat_oe, 0);
    chk("rst_ready",  pkt_ready, 1);
    chk("rst_done",   done, 0);
    reset_n = 1'b1;
    repeat (100) tick();
    chk("idle_no_clock", fall_cnt, 0);
    chk("idle_clk_oe",   ps2_clk_oe, 0);
    chk("idle_dat_oe",   ps2_dat_oe, 0);

    // Table-driven packets.
    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      repeat (5) tick();
      bits.delete();
      d0 = done_cnt;
      send(vecs[i].dx, vecs[i].dy, vecs[i].btn, t);
      start_checks(nm);
      if (i == 0) begin
        repeat (CH - 1) tick();
        chk("first_half_clk_released", ps2_clk_oe, 0);
        tick();
        chk("first_fall_edge", ps2_clk_oe, 1);
      end
      finish_pkt(nm, t, d0, 1'b1, vecs[i].f0, vecs[i].f1, vecs[i].f2);
    end

    // Busy: second request mid-packet is dropped; request right after done starts.
    repeat (5) tick();
    bits.delete();
    d0 = done_cnt;
    send(12, 34, 2, t);
    repeat (49) tick();
    delta_x   = 9'(-100);
    delta_y   = 9'(77);
    buttons   = 3'b101;
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    finish_pkt("busy_a", t, d0, 1'b1, model_frame(12, 34, 2, 0),
               model_frame(12, 34, 2, 1), model_frame(12, 34, 2, 2));
    bits.delete();
    d0 = done_cnt;
    send(-100, 77, 5, t2);
    start_checks("busy_b");
    finish_pkt("busy_b", t2, d0, 1'b1, model_frame(-100, 77, 5, 0),
               model_frame(-100, 77, 5, 1), model_frame(-100, 77, 5, 2));

    // Reset during the low phase of byte1 bit 4.
    repeat (5) tick();
    bits.delete();
    d0 = done_cnt;
    send(5, -3, 1, t);
    repeat (133) tick();
    chk("midrst_pre_clk_oe", ps2_clk_oe, 1);
    chk("midrst_pre_dat_oe", ps2_dat_oe, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_clk_oe", ps2_clk_oe, 0);
    chk("midrst_dat_oe", ps2_dat_oe, 0);
    chk("midrst_ready",  pkt_ready, 1);
    chk("midrst_done",   done, 0);
    fc = fall_cnt;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (100) tick();
    chk("midrst_no_resume_edges", fall_cnt - fc, 0);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_idle_clk_oe", ps2_clk_oe, 0);

    // Host holds the clock low during byte0 bit 3.
    repeat (5) tick();
    bits.delete();
    d0 = done_cnt;
    send(5, -3, 1, t);
    repeat (24) tick();
    host_pull = 1'b1;
    repeat (4) tick();
`ifdef PS2_TX_INHIBIT_DETECT_EN
    chk("inhibit_clk_released", ps2_clk_oe, 0);
    chk("inhibit_dat_released", ps2_dat_oe, 0);
`else
    chk("inhibit_ignored_clk_oe", ps2_clk_oe, 1);
`endif
    repeat (16) tick();
    host_pull = 1'b0;
`ifdef PS2_TX_INHIBIT_DETECT_EN
    bits.delete();
    finish_pkt("inhibit", t, d0, 1'b0, mk_frame(8'h29, 1'b0), mk_frame(8'h05, 1'b1),
               mk_frame(8'hFD, 1'b0));
`else
    finish_pkt("inhibit", t, d0, 1'b1, mk_frame(8'h29, 1'b0), mk_frame(8'h05, 1'b1),
               mk_frame(8'hFD, 1'b0));
`endif
    repeat (50) tick();
    chk("inhibit_one_done", done_cnt - d0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
